vram_160x100: RTL and testbench

Single-clock 160x100x8 (RGB332) video memory with a write port on the pixel clock, a coordinate-to-address stage and a hardware clear engine. It sits directly upstream of the 640x400 VGA scan generator. It supplies the byte that generator fetches for each 4x4 pixel block through a registered read port. Writes are taken in (x, y) form and converted to a linear address. Out-of-range writes are dropped and counted.

---
 rtl/vram_160x100.sv | 112 +++++++++++
 tb/tb_vram_160x100.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vram_160x100.sv
// 160x100 RGB332 frame store: (x,y) writes commit 1 edge after acceptance, reads register in 1 cycle, and a clear engine fills all locations.
// wr_ready drops while clr_req is high and for the whole fill; out-of-range writes are accepted, discarded and counted.
module vram_160x100 #(
  parameter int W  = 160,
  parameter int H  = 100,
  parameter int AW = 14
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [7:0]    wr_x,
  input  logic [6:0]    wr_y,
  input  logic [7:0]    wr_data,
  input  logic          clr_req,
  input  logic [7:0]    clr_color,
  output logic          busy,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_dout,
  output logic [7:0]    drop_cnt
);
  localparam int            DEPTH = W * H;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [7:0]    X_LIM = 8'(W);
  localparam logic [6:0]    Y_LIM = 7'(H);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt;
  logic [7:0]    clr_col;

  logic          s1_vld;
  logic [AW-1:0] s1_addr;
  logic [7:0]    s1_dat;

  logic [AW-1:0] x_ext, y_ext, wr_addr;
  logic          in_range, wr_fire;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dat;
  logic [7:0]    mem [0:DEPTH-1];

  assign wr_ready = ~reset & (state == IDLE) & ~clr_req;
  assign wr_fire  = wr_valid & wr_ready;

  // y*160 as two shifts keeps the multiplier out of the write path
  assign x_ext    = AW'(wr_x);
  assign y_ext    = AW'(wr_y);
  assign wr_addr  = (y_ext << 7) + (y_ext << 5) + x_ext;
  assign in_range = (wr_x < X_LIM) & (wr_y < Y_LIM);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (clr_req) state_nxt = CLEAR;
      CLEAR: if (clr_cnt == LAST) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      clr_cnt <= '0;
      clr_col <= 8'h00;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == CLEAR);
      if (state == IDLE && clr_req) begin
        clr_cnt <= '0;
        clr_col <= clr_color;
      end else if (state == CLEAR) begin
        clr_cnt <= clr_cnt + AW'(1);
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      s1_vld   <= 1'b0;
      s1_addr  <= '0;
      s1_dat   <= 8'h00;
      drop_cnt <= 8'h00;
    end else begin
      s1_vld <= wr_fire & in_range;
      if (wr_fire) begin
        s1_addr <= wr_addr;
        s1_dat  <= wr_data;
        if (!in_range && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // A pending stage-1 write always commits on the edge that samples clr_req,
  // so the fill and the write port never collide and the fill wins.
  always_comb begin
    ram_we   = (state == CLEAR) | s1_vld;
    ram_addr = (state == CLEAR) ? clr_cnt : s1_addr;
    ram_dat  = (state == CLEAR) ? clr_col : s1_dat;
  end

  always_ff @(posedge pclk) begin
    if (ram_we) mem[ram_addr] <= ram_dat;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) vid_dout <= 8'h00;
    else       vid_dout <= mem[vid_addr];
  end
endmodule

// File: tb/tb_vram_160x100.sv
// Directed bench for vram_160x100: writes, drops, fill timing, fill restart immunity, reset mid-fill, read-during-write.
module tb_vram_160x100;
  logic        pclk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [7:0]  wr_data;
  logic        clr_req;
  logic [7:0]  clr_color;
  logic        busy;
  logic [13:0] vid_addr;
  logic [7:0]  vid_dout;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  vram_160x100 dut (
    .pclk(pclk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .clr_req(clr_req),
    .clr_color(clr_color), .busy(busy), .vid_addr(vid_addr),
    .vid_dout(vid_dout), .drop_cnt(drop_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the commit edge.
  task automatic wr_px(input logic [7:0] x, input logic [6:0] y, input logic [7:0] d);
    wr_valid = 1'b1; wr_x = x; wr_y = y; wr_data = d;
    @(posedge pclk); @(negedge pclk);
    wr_valid = 1'b0;
    @(posedge pclk); @(negedge pclk);
  endtask

  task automatic rd(input logic [13:0] a, output logic [7:0] q);
    vid_addr = a;
    @(posedge pclk); @(negedge pclk);
    q = vid_dout;
  endtask

  initial begin
    logic [7:0] q;
    int n, errs;

    reset = 1'b1; wr_valid = 1'b0; wr_x = 8'd0; wr_y = 7'd0; wr_data = 8'h00;
    clr_req = 1'b0; clr_color = 8'h00; vid_addr = 14'd0;
    @(negedge pclk); @(negedge pclk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dout", 32'(vid_dout), 32'h00);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd0);
    reset = 1'b0;
    #1 chk("ready_idle", 32'(wr_ready), 32'd1);

    wr_px(8'd3, 7'd2, 8'hE0);
    rd(14'd323, q);      chk("rd_323", 32'(q), 32'hE0);

    wr_px(8'd159, 7'd99, 8'h1C);
    wr_px(8'd0, 7'd0, 8'h03);
    wr_px(8'd0, 7'd1, 8'h42);
    rd(14'd15999, q);    chk("rd_15999", 32'(q), 32'h1C);
    rd(14'd0, q);        chk("rd_0", 32'(q), 32'h03);

    wr_px(8'd160, 7'd0, 8'hFF);
    wr_px(8'd0, 7'd100, 8'hFF);
    chk("drop_2", 32'(drop_cnt), 32'd2);
    rd(14'd160, q);      chk("rd_160_kept", 32'(q), 32'h42);
    rd(14'd0, q);        chk("rd_0_kept", 32'(q), 32'h03);

    wr_valid = 1'b1; wr_x = 8'd200; wr_y = 7'd5;
    for (int i = 0; i < 300; i++) begin
      @(posedge pclk); @(negedge pclk);
    end
    wr_valid = 1'b0;
    chk("drop_sat", 32'(drop_cnt), 32'd255);

    // Fill while a write sits in stage 1
    wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd5; wr_data = 8'h99;
    @(posedge pclk); @(negedge pclk);
    wr_valid = 1'b0; clr_req = 1'b1; clr_color = 8'h55;
    #1 chk("ready_clrreq", 32'(wr_ready), 32'd0);
    n = 1;
    @(posedge pclk); @(negedge pclk);
    clr_req = 1'b0; clr_color = 8'h00;
    chk("busy_rise", 32'(busy), 32'd1);
    for (int i = 0; i < 20000; i++) begin
      if (wr_ready) break;
      n++;
      @(posedge pclk); @(negedge pclk);
    end
    chk("ready_low_cycles", 32'(n), 32'd16001);
    chk("busy_fall", 32'(busy), 32'd0);
    errs = 0;
    for (int a = 0; a < 16000; a++) begin
      rd(14'(a), q);
      if (q !== 8'h55) errs++;
    end
    chk("fill_all_55", 32'(errs), 32'd0);
    rd(14'd805, q);      chk("fill_inflight", 32'(q), 32'h55);

    // Repeated clr_req during a fill must not restart it or relatch color
    clr_req = 1'b1; clr_color = 8'h11;
    @(posedge pclk); @(negedge pclk);
    clr_req = 1'b0; clr_color = 8'hEE;
    n = 0;
    for (int i = 0; i < 20000; i++) begin
      clr_req = (n == 100 || n == 8000);
      @(posedge pclk); n++; @(negedge pclk);
      if (!busy) break;
    end
    clr_req = 1'b0;
    chk("fill_len_pulses", 32'(n), 32'd16000);
    rd(14'd0, q);        chk("fill2_first", 32'(q), 32'h11);
    rd(14'd15999, q);    chk("fill2_last", 32'(q), 32'h11);

    // Reset after 5000 fill writes
    clr_req = 1'b1; clr_color = 8'h55;
    @(posedge pclk); @(negedge pclk);
    clr_req = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge pclk);
    end
    @(negedge pclk);
    reset = 1'b1;
    #1 chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(wr_ready), 32'd0);
    @(negedge pclk);
    reset = 1'b0;
    chk("rst_mid_drop", 32'(drop_cnt), 32'd0);
    #1 chk("rst_mid_ready_back", 32'(wr_ready), 32'd1);
    rd(14'd0, q);        chk("partial_0", 32'(q), 32'h55);
    rd(14'd4999, q);     chk("partial_4999", 32'(q), 32'h55);
    rd(14'd5000, q);     chk("partial_5000", 32'(q), 32'h11);
    rd(14'd15999, q);    chk("partial_15999", 32'(q), 32'h11);
    wr_px(8'd7, 7'd0, 8'h3C);
    rd(14'd7, q);        chk("post_rst_write", 32'(q), 32'h3C);

    // Read and write of address 77 on the same edge
    wr_valid = 1'b1; wr_x = 8'd77; wr_y = 7'd0; wr_data = 8'hAA;
    @(posedge pclk); @(negedge pclk);
    wr_valid = 1'b0; vid_addr = 14'd77;
    @(posedge pclk); @(negedge pclk);
    chk("rdw_old", 32'(vid_dout), 32'h55);
    @(posedge pclk); @(negedge pclk);
    chk("rdw_new", 32'(vid_dout), 32'hAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
